// File: rtl/ifetch_stage_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, exception codes, default vectors.
package ifetch_stage_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] DEF_EX_ENTRY = 32'hBFC0_0380;
   localparam logic [4:0]  EX_ADEL      = 5'h04;

   typedef enum logic {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_e;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ifetch_stage_npc_sel.sv
// Next fetch-PC priority mux: exception entry, then ERET, then branch target, then sequential.
module ifetch_stage_npc_sel (
   input  logic        ex_flush,
   input  logic        eret_flush,
   input  logic [31:0] ex_entry,
   input  logic [31:0] cp0_epc,
   input  logic        br_take,
   input  logic [31:0] br_target,
   input  logic [31:0] fetch_pc,
   output logic [31:0] next_pc
);

   always_comb begin
      next_pc = fetch_pc + 32'd4;
      if (ex_flush)
         next_pc = ex_entry;
      else if (eret_flush)
         next_pc = cp0_epc;
      else if (br_take)
         next_pc = br_target;
   end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: PC ownership, single-outstanding SRAM handshake, redirect and flush handling.
module ifetch_stage
   import ifetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] EX_ENTRY = DEF_EX_ENTRY
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        ex_flush,
   input  logic        eret_flush,
   input  logic [31:0] cp0_epc,
   output logic        inst_sram_req,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] inst,
   output logic        if_cp0_ex,
   output logic [4:0]  if_cp0_excode,
   output logic [31:0] if_badvaddr
);

   fetch_state_e state, state_nxt;
   logic [31:0]  fetch_pc, inflight_pc, br_target_q, target_sel, next_pc;
   logic         br_pending, ds_issued, discard;
   logic         flush, busy, br_new, issue_ok, accept, exc_load, load_data, advance;
   logic         br_take, wrong_path, redir;

   assign flush          = ex_flush | eret_flush;
   assign busy           = if_valid | (state == S_WAIT);
   assign br_new         = br_taken & ~flush;
   assign accept         = inst_sram_req & inst_sram_addr_ok;
   assign advance        = accept | exc_load;
   assign inst_sram_addr = fetch_pc;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_REQ;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_REQ:   if (accept) state_nxt = S_WAIT;
         S_WAIT:  if (inst_sram_data_ok) state_nxt = S_REQ;
         default: state_nxt = S_REQ;
      endcase
   end

   always_comb begin
      issue_ok      = !reset && (state == S_REQ) && (!if_valid || id_allowin) && !flush;
      inst_sram_req = issue_ok && !misaligned(fetch_pc);
      exc_load      = issue_ok && misaligned(fetch_pc);
      load_data     = !reset && (state == S_WAIT) && inst_sram_data_ok && !discard && !flush;
   end

   // Redirect as soon as the delay slot is out (or leaving now); an address already
   // presented is held until accepted, and that wrong-path fetch is then discarded.
   always_comb begin
      br_take    = 1'b0;
      wrong_path = 1'b0;
      target_sel = br_target_q;
      if (br_new) begin
         br_take    = busy || advance;
         wrong_path = busy;
         target_sel = br_target;
      end else if (br_pending) begin
         br_take    = ds_issued || advance;
         wrong_path = ds_issued;
      end
      redir = br_take && (advance || !inst_sram_req);
   end

   ifetch_stage_npc_sel u_npc_sel (
      .ex_flush   (ex_flush),
      .eret_flush (eret_flush),
      .ex_entry   (EX_ENTRY),
      .cp0_epc    (cp0_epc),
      .br_take    (br_take),
      .br_target  (target_sel),
      .fetch_pc   (fetch_pc),
      .next_pc    (next_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc      <= RESET_PC;
         inflight_pc   <= '0;
         br_target_q   <= '0;
         br_pending    <= 1'b0;
         ds_issued     <= 1'b0;
         discard       <= 1'b0;
         if_valid      <= 1'b0;
         if_pc         <= '0;
         inst          <= '0;
         if_cp0_ex     <= 1'b0;
         if_cp0_excode <= '0;
         if_badvaddr   <= '0;
      end else begin
         if (flush || advance || redir)
            fetch_pc <= next_pc;
         if (accept)
            inflight_pc <= fetch_pc;

         if (flush || redir) begin
            br_pending <= 1'b0;
            ds_issued  <= 1'b0;
         end else if (br_new) begin
            br_pending  <= 1'b1;
            br_target_q <= br_target;
            ds_issued   <= busy;
         end

         if (state == S_WAIT) begin
            if (inst_sram_data_ok)
               discard <= 1'b0;
            else if (flush)
               discard <= 1'b1;
         end else if (accept && wrong_path) begin
            discard <= 1'b1;
         end

         if (flush)
            if_valid <= 1'b0;
         else if (load_data || exc_load)
            if_valid <= 1'b1;
         else if (id_allowin)
            if_valid <= 1'b0;

         if (load_data) begin
            inst          <= inst_sram_rdata;
            if_pc         <= inflight_pc;
            if_cp0_ex     <= 1'b0;
            if_cp0_excode <= '0;
            if_badvaddr   <= '0;
         end else if (exc_load) begin
            inst          <= '0;
            if_pc         <= fetch_pc;
            if_cp0_ex     <= 1'b1;
            if_cp0_excode <= EX_ADEL;
            if_badvaddr   <= fetch_pc;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: handshake, stall, delay slot, flushes, misaligned fetch, reset.
module tb_ifetch_stage;

   logic        clk = 1'b0;
   logic        reset, id_allowin, br_taken, ex_flush, eret_flush;
   logic [31:0] br_target, cp0_epc;
   logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_addr, inst_sram_rdata;
   logic        if_valid, if_cp0_ex;
   logic [31:0] if_pc, inst, if_badvaddr;
   logic [4:0]  if_cp0_excode;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ifetch_stage #(
      .RESET_PC (32'hBFC0_0000),
      .EX_ENTRY (32'hBFC0_0380)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .id_allowin        (id_allowin),
      .br_taken          (br_taken),
      .br_target         (br_target),
      .ex_flush          (ex_flush),
      .eret_flush        (eret_flush),
      .cp0_epc           (cp0_epc),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .if_valid          (if_valid),
      .if_pc             (if_pc),
      .inst              (inst),
      .if_cp0_ex         (if_cp0_ex),
      .if_cp0_excode     (if_cp0_excode),
      .if_badvaddr       (if_badvaddr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic aok, input logic dok, input logic allow, input logic [31:0] rd);
      inst_sram_addr_ok = aok;
      inst_sram_data_ok = dok;
      id_allowin        = allow;
      inst_sram_rdata   = rd;
      #1;
   endtask

   initial begin
      reset = 1'b1; id_allowin = 1'b0; br_taken = 1'b0; ex_flush = 1'b0; eret_flush = 1'b0;
      br_target = '0; cp0_epc = '0;
      inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
      tick();
      check("rst_req",      32'(inst_sram_req), 32'd0);
      check("rst_valid",    32'(if_valid),      32'd0);
      check("rst_pc",       if_pc,              32'd0);
      check("rst_inst",     inst,               32'd0);
      check("rst_ex",       32'(if_cp0_ex),     32'd0);
      check("rst_excode",   32'(if_cp0_excode), 32'd0);
      check("rst_badvaddr", if_badvaddr,        32'd0);
      reset = 1'b0;

      // first fetch
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t1_req",  32'(inst_sram_req), 32'd1);
      check("t1_addr", inst_sram_addr,     32'hBFC0_0000);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h2401_0001);
      check("t1_wait_req", 32'(inst_sram_req), 32'd0);
      tick();
      check("t1_valid", 32'(if_valid), 32'd1);
      check("t1_pc",    if_pc,         32'hBFC0_0000);
      check("t1_inst",  inst,          32'h2401_0001);

      // decode stall
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 1'b0, '0);
         check("t2_stall_req", 32'(inst_sram_req), 32'd0);
         tick();
         check("t2_hold_valid", 32'(if_valid), 32'd1);
         check("t2_hold_pc",    if_pc,         32'hBFC0_0000);
         check("t2_hold_inst",  inst,          32'h2401_0001);
      end
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t2_resume_req",  32'(inst_sram_req), 32'd1);
      check("t2_resume_addr", inst_sram_addr,     32'hBFC0_0004);
      tick();
      check("t2_xfer_valid", 32'(if_valid), 32'd0);
      drive(1'b0, 1'b1, 1'b1, 32'h8C22_0004);
      tick();
      check("t2_pc",   if_pc, 32'hBFC0_0004);
      check("t2_inst", inst,  32'h8C22_0004);

      // branch resolves while delay slot is in flight
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t3_ds_addr", inst_sram_addr, 32'hBFC0_0008);
      tick();
      br_taken = 1'b1; br_target = 32'hBFC0_0100;
      drive(1'b0, 1'b0, 1'b1, '0);
      check("t3_br_req", 32'(inst_sram_req), 32'd0);
      tick();
      br_taken = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 32'h3C08_BFC0);
      tick();
      check("t3_ds_pc",   if_pc, 32'hBFC0_0008);
      check("t3_ds_inst", inst,  32'h3C08_BFC0);
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t3_tgt_req",  32'(inst_sram_req), 32'd1);
      check("t3_tgt_addr", inst_sram_addr,     32'hBFC0_0100);
      tick();

      // exception flush while waiting, stale data two cycles later
      ex_flush = 1'b1;
      drive(1'b0, 1'b0, 1'b1, '0);
      check("t4_flush_req", 32'(inst_sram_req), 32'd0);
      tick();
      ex_flush = 1'b0;
      check("t4_flush_valid", 32'(if_valid), 32'd0);
      drive(1'b0, 1'b0, 1'b1, '0);
      check("t4_wait_req", 32'(inst_sram_req), 32'd0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      check("t4_stale_req", 32'(inst_sram_req), 32'd0);
      tick();
      check("t4_drop_valid", 32'(if_valid), 32'd0);
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t4_entry_req",  32'(inst_sram_req), 32'd1);
      check("t4_entry_addr", inst_sram_addr,     32'hBFC0_0380);
      tick();

      // ERET to misaligned EPC
      drive(1'b0, 1'b1, 1'b1, 32'h4080_6000);
      tick();
      check("t5_pre_valid", 32'(if_valid), 32'd1);
      check("t5_pre_pc",    if_pc,         32'hBFC0_0380);
      eret_flush = 1'b1; cp0_epc = 32'hBFC0_0102;
      drive(1'b1, 1'b0, 1'b0, '0);
      check("t5_eret_req", 32'(inst_sram_req), 32'd0);
      tick();
      eret_flush = 1'b0;
      check("t5_eret_valid", 32'(if_valid), 32'd0);
      drive(1'b1, 1'b0, 1'b0, '0);
      check("t5_mis_req", 32'(inst_sram_req), 32'd0);
      tick();
      check("t5_valid",    32'(if_valid),      32'd1);
      check("t5_ex",       32'(if_cp0_ex),     32'd1);
      check("t5_excode",   32'(if_cp0_excode), 32'h04);
      check("t5_badvaddr", if_badvaddr,        32'hBFC0_0102);
      check("t5_inst",     inst,               32'd0);
      check("t5_pc",       if_pc,              32'hBFC0_0102);
      drive(1'b1, 1'b0, 1'b0, '0);
      check("t5_hold_req", 32'(inst_sram_req), 32'd0);
      tick();
      check("t5_hold_bad", if_badvaddr, 32'hBFC0_0102);

      // ex_flush and eret_flush together, coincident with data_ok
      ex_flush = 1'b1;
      drive(1'b0, 1'b0, 1'b1, '0);
      tick();
      ex_flush = 1'b0;
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t6_entry_addr", inst_sram_addr, 32'hBFC0_0380);
      tick();
      ex_flush = 1'b1; eret_flush = 1'b1; cp0_epc = 32'hBFC0_0200;
      drive(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
      check("t6_both_req", 32'(inst_sram_req), 32'd0);
      tick();
      ex_flush = 1'b0; eret_flush = 1'b0;
      check("t6_drop_valid", 32'(if_valid), 32'd0);
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t6_req",  32'(inst_sram_req), 32'd1);
      check("t6_addr", inst_sram_addr,     32'hBFC0_0380);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h27BD_FFE8);
      tick();
      check("t6_load_valid", 32'(if_valid), 32'd1);
      check("t6_load_inst",  inst,          32'h27BD_FFE8);

      // reset in the middle of a fetch, stale data_ok afterwards
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t7_addr", inst_sram_addr, 32'hBFC0_0384);
      tick();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b1, '0);
      check("t7_rst_req", 32'(inst_sram_req), 32'd0);
      tick();
      reset = 1'b0;
      check("t7_rst_valid", 32'(if_valid), 32'd0);
      check("t7_rst_pc",    if_pc,         32'd0);
      drive(1'b0, 1'b1, 1'b1, 32'hBAAD_F00D);
      check("t7_req",  32'(inst_sram_req), 32'd1);
      check("t7_addr2", inst_sram_addr,    32'hBFC0_0000);
      tick();
      check("t7_stale_valid", 32'(if_valid), 32'd0);

      // branch while IF idle: delay slot is fetch_pc, target follows it
      br_taken = 1'b1; br_target = 32'hBFC0_0040;
      drive(1'b0, 1'b0, 1'b1, '0);
      check("t8_ds_req",  32'(inst_sram_req), 32'd1);
      check("t8_ds_addr", inst_sram_addr,     32'hBFC0_0000);
      tick();
      br_taken = 1'b0;
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t8_ds_addr2", inst_sram_addr, 32'hBFC0_0000);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h0085_1021);
      tick();
      check("t8_ds_pc",   if_pc, 32'hBFC0_0000);
      check("t8_ds_inst", inst,  32'h0085_1021);
      drive(1'b1, 1'b0, 1'b1, '0);
      check("t8_tgt_addr", inst_sram_addr, 32'hBFC0_0040);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h1111_1111);
      tick();
      check("t8_tgt_pc", if_pc, 32'hBFC0_0040);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
